// File: rtl/store_buffer.sv
// In-order store queue: holds ACU stores until ROB commit, then drains them to MEM in program order.
// Optional squash input (flush of uncommitted entries) is enabled by defining SB_SQUASH_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package sb_pkg;
  typedef struct packed {
    logic                    valid;
    logic [`XLEN-1:0]        address;
    logic [`XLEN-1:0]        data;
    logic [`ROB_TAG_LEN-1:0] rob_tag;
    logic [1:0]              mem_size;
  } SB_PACKET;
endpackage

// Handshakes: a packet is taken on a posedge where alloc_enable && valid && !full;
// write_mem is a request that completes on the posedge it is high (mem_busy acts as an inverted ready).
module store_buffer #(
  parameter int SB_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  sb_pkg::SB_PACKET        sb_packet_in,
  input  logic                    alloc_enable,
  input  logic                    commit_store,
  input  logic                    mem_busy,
`ifdef SB_SQUASH_EN
  input  logic                    squash,
`endif
  output logic                    full,
  output logic                    pending_stores,
  output logic [`XLEN-1:0]        store_address,
  output logic [`ROB_TAG_LEN-1:0] store_rob_tag,
  output logic                    write_mem,
  output logic [`XLEN-1:0]        mem_address,
  output logic [`XLEN-1:0]        mem_data,
  output logic [1:0]              mem_size
);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_COMMITTED} entry_state_e;

  entry_state_e            st_q   [SB_DEPTH];
  entry_state_e            st_d   [SB_DEPTH];
  logic [`XLEN-1:0]        addr_q [SB_DEPTH];
  logic [`XLEN-1:0]        addr_d [SB_DEPTH];
  logic [`XLEN-1:0]        data_q [SB_DEPTH];
  logic [`XLEN-1:0]        data_d [SB_DEPTH];
  logic [1:0]              size_q [SB_DEPTH];
  logic [1:0]              size_d [SB_DEPTH];

  logic [PW-1:0]           head_q, head_d, tail_q, tail_d, cptr_q, cptr_d;
  logic [CW-1:0]           count_q, count_d, ccount_q, ccount_d;
  logic [`XLEN-1:0]        store_address_q, store_address_d;
  logic [`ROB_TAG_LEN-1:0] store_rob_tag_q, store_rob_tag_d;

  logic alloc_ok, alloc_acc, commit_ok, drain, squash_now;

  always_comb begin
`ifdef SB_SQUASH_EN
    squash_now = squash;
`else
    squash_now = 1'b0;
`endif
    alloc_ok  = alloc_enable && sb_packet_in.valid && (count_q != CW'(SB_DEPTH));
    alloc_acc = alloc_ok && !squash_now;
    // Only entries already waiting before this edge can be committed.
    commit_ok = commit_store && (count_q != ccount_q);
    drain     = (ccount_q != '0) && !mem_busy;

    st_d   = st_q;
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    head_d = drain     ? head_q + PW'(1) : head_q;
    cptr_d = commit_ok ? cptr_q + PW'(1) : cptr_q;
    tail_d = alloc_acc ? tail_q + PW'(1) : tail_q;
    count_d  = count_q  + CW'(alloc_acc) - CW'(drain);
    ccount_d = ccount_q + CW'(commit_ok) - CW'(drain);
    store_address_d = store_address_q;
    store_rob_tag_d = store_rob_tag_q;

    if (drain)     st_d[head_q] = ST_FREE;
    if (commit_ok) st_d[cptr_q] = ST_COMMITTED;
    if (alloc_acc) begin
      st_d[tail_q]    = ST_WAIT;
      addr_d[tail_q]  = sb_packet_in.address;
      data_d[tail_q]  = sb_packet_in.data;
      size_d[tail_q]  = sb_packet_in.mem_size;
      store_address_d = sb_packet_in.address;
      store_rob_tag_d = sb_packet_in.rob_tag;
    end

    // Squash drops everything younger than the commit point, after this edge's commit/drain.
    if (squash_now) begin
      tail_d  = cptr_d;
      count_d = ccount_d;
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (st_d[i] == ST_WAIT) st_d[i] = ST_FREE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      cptr_q          <= '0;
      count_q         <= '0;
      ccount_q        <= '0;
      store_address_q <= '0;
      store_rob_tag_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) st_q[i] <= ST_FREE;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      cptr_q          <= cptr_d;
      count_q         <= count_d;
      ccount_q        <= ccount_d;
      store_address_q <= store_address_d;
      store_rob_tag_q <= store_rob_tag_d;
      st_q            <= st_d;
    end
  end

  // Payload storage needs no reset: it is only visible through a non-FREE entry.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    data_q <= data_d;
    size_q <= size_d;
  end

  assign full           = (count_q == CW'(SB_DEPTH));
  assign pending_stores = (count_q != '0);
  assign store_address  = store_address_q;
  assign store_rob_tag  = store_rob_tag_q;
  assign write_mem      = drain;
  assign mem_address    = (st_q[head_q] != ST_FREE) ? addr_q[head_q] : '0;
  assign mem_data       = (st_q[head_q] != ST_FREE) ? data_q[head_q] : '0;
  assign mem_size       = (st_q[head_q] != ST_FREE) ? size_q[head_q] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model;
// define SB_SQUASH_EN to also exercise squash.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int XL    = `XLEN;
  localparam int TL    = `ROB_TAG_LEN;
  localparam int PKW   = 1 + 2 * XL + TL + 2;
  localparam int EW    = 2 * XL + 2;

  logic           clock, reset;
  logic [PKW-1:0] sb_packet_in;
  logic           alloc_enable, commit_store, mem_busy;
`ifdef SB_SQUASH_EN
  logic           squash;
`endif
  logic           full, pending_stores, write_mem;
  logic [XL-1:0]  store_address, mem_address, mem_data;
  logic [TL-1:0]  store_rob_tag;
  logic [1:0]     mem_size;

  store_buffer #(.SB_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .sb_packet_in(sb_packet_in),
    .alloc_enable(alloc_enable), .commit_store(commit_store), .mem_busy(mem_busy),
`ifdef SB_SQUASH_EN
    .squash(squash),
`endif
    .full(full), .pending_stores(pending_stores), .store_address(store_address),
    .store_rob_tag(store_rob_tag), .write_mem(write_mem), .mem_address(mem_address),
    .mem_data(mem_data), .mem_size(mem_size)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model: queue of occupied stores, the oldest ncom of which are committed
  typedef struct {
    logic [XL-1:0] a;
    logic [XL-1:0] d;
    logic [1:0]    sz;
  } ent_t;
  ent_t          mq[$];
  int            ncom;
  logic [XL-1:0] m_addr;
  logic [TL-1:0] m_tag;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every write presented to MEM must match the oldest expected write
  always @(negedge clock) begin
    if (reset && write_mem) begin
      n_writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h expected no write", mem_address);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({mem_address, mem_data, mem_size} !== e) begin
          errors++;
          $display("FAIL write_payload: got %0h/%0h/%0h expected %0h/%0h/%0h",
                   mem_address, mem_data, mem_size, e[EW-1 -: XL], e[XL+1 -: XL], e[1:0]);
        end
      end
    end
  end

  // driver: one cycle of stimulus; entered and left at posedge+1
  task automatic cycle(input logic en, input logic vld, input logic [XL-1:0] a,
                       input logic [XL-1:0] d, input logic [TL-1:0] t, input logic [1:0] sz,
                       input logic cm, input logic bs, input logic sq);
    int  n_old, c_old;
    logic acc, cmt, drn;
    ent_t e;
    alloc_enable = en;
    sb_packet_in = {vld, a, d, t, sz};
    commit_store = cm;
    mem_busy     = bs;
`ifdef SB_SQUASH_EN
    squash       = sq;
`endif
    n_old = mq.size();
    c_old = ncom;
    acc = en && vld && (n_old < DEPTH) && !sq;
    cmt = cm && (c_old < n_old);
    drn = (c_old > 0) && !bs;
    if (drn) exp_q.push_back({mq[0].a, mq[0].d, mq[0].sz});

    @(negedge clock);
    chk("full", full, n_old == DEPTH);
    chk("pending_stores", pending_stores, n_old != 0);
    chk("write_mem", write_mem, drn);
    chk("store_address", store_address, m_addr);
    chk("store_rob_tag", store_rob_tag, m_tag);
    chk("mem_address", mem_address, (n_old != 0) ? mq[0].a : '0);
    chk("mem_data", mem_data, (n_old != 0) ? mq[0].d : '0);
    chk("mem_size", mem_size, (n_old != 0) ? mq[0].sz : 2'd0);

    @(posedge clock);
    #1;
    if (cmt) ncom++;
    if (drn) begin
      void'(mq.pop_front());
      ncom--;
    end
    if (acc) begin
      e.a = a; e.d = d; e.sz = sz;
      mq.push_back(e);
      m_addr = a;
      m_tag  = t;
    end
    if (sq) while (mq.size() > ncom) void'(mq.pop_back());
  endtask

  task automatic idle(input logic cm, input logic bs);
    cycle(1'b0, 1'b0, '0, '0, '0, 2'd0, cm, bs, 1'b0);
  endtask

  task automatic alloc(input logic [XL-1:0] a, input logic [XL-1:0] d, input logic [TL-1:0] t,
                       input logic [1:0] sz, input logic cm, input logic bs);
    cycle(1'b1, 1'b1, a, d, t, sz, cm, bs, 1'b0);
  endtask

  initial begin
    int w0;
    reset = 1'b0;
    alloc_enable = 1'b0; commit_store = 1'b0; mem_busy = 1'b0; sb_packet_in = '0;
`ifdef SB_SQUASH_EN
    squash = 1'b0;
`endif
    ncom = 0; m_addr = '0; m_tag = '0;

    // reset state
    repeat (2) @(negedge clock);
    chk("rst_full", full, 0);
    chk("rst_pending", pending_stores, 0);
    chk("rst_write_mem", write_mem, 0);
    chk("rst_store_address", store_address, 0);
    chk("rst_store_rob_tag", store_rob_tag, 0);
    chk("rst_mem_address", mem_address, 0);
    @(posedge clock);
    #1 reset = 1'b1;

    // allocation visibility, commit, drain
    alloc(32'h10, 32'hAA, 2, 2, 0, 0);
    idle(0, 0);
    idle(1, 0);
    idle(0, 0);
    idle(0, 0);

    // fill, reject fifth, commit under busy, then drain
    for (int i = 1; i <= 4; i++) alloc(32'h100 + 32'(i) * 4, 32'hD0 + 32'(i), TL'(i), 2'(i), 0, 0);
    alloc(32'h200, 32'hEE, 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) idle(1, 1);
    idle(0, 1);
    for (int i = 0; i < 6; i++) idle(0, 0);

    // wrap-around through the ring
    for (int i = 0; i < 6; i++) begin
      alloc(32'(i) * 4, 32'h5000 + 32'(i), TL'(i + 8), 2'(i), 0, 0);
      idle(1, 0);
    end
    repeat (3) idle(0, 0);

    // same-cycle alloc + commit into an empty buffer: commit is ignored
    alloc(32'h40, 32'h77, 3, 1, 1, 0);
    idle(0, 0);
    idle(0, 0);
    idle(1, 0);
    idle(0, 0);
    idle(0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic sq;
      sq = 1'b0;
`ifdef SB_SQUASH_EN
      sq = ($urandom_range(0, 19) == 0);
`endif
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom, $urandom,
            TL'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3, sq);
    end
    for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1, 0);
    idle(0, 0);

    // asynchronous reset mid-operation discards everything
    alloc(32'h300, 32'h1, 7, 0, 0, 1);
    alloc(32'h304, 32'h2, 8, 0, 1, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pending", pending_stores, 0);
    chk("async_rst_write_mem", write_mem, 0);
    chk("async_rst_store_address", store_address, 0);
    chk("async_rst_mem_address", mem_address, 0);
    mq.delete(); ncom = 0; m_addr = '0; m_tag = '0; exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b1;
    idle(1, 0);
    idle(0, 0);

`ifdef SB_SQUASH_EN
    // three entries, oldest committed, then squash with a simultaneous alloc
    alloc(32'h400, 32'h11, 1, 0, 0, 1);
    alloc(32'h404, 32'h22, 2, 0, 1, 1);
    alloc(32'h408, 32'h33, 3, 0, 0, 1);
    cycle(1'b1, 1'b1, 32'h40C, 32'h44, 4, 0, 1'b0, 1'b1, 1'b1);
    idle(0, 1);
    w0 = n_writes;
    for (int i = 0; i < 4; i++) idle(0, 0);
    chk("squash_write_count", n_writes - w0, 1);
    chk("squash_pending_after", pending_stores, 0);
`endif

    w0 = n_writes;
    chk("final_exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion before bound");
    $fatal(1);
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Multi-entry in-order store queue. It is the write-side counterpart of load_buffer.
- Accepts address-computed stores from the ACU and reports each allocation to the ROB.
- Holds each store until the ROB commits it, then drains committed stores to MEM in program order.
- Drives pending_stores, which gates load issue in load_buffer.

Parameters:
- SB_DEPTH, 4, number of entries; power of two, at least 2. Counter width is $clog2(SB_DEPTH)+1.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- sb_packet_in  in  SB_PACKET  {valid, address[`XLEN], data[`XLEN], rob_tag[`ROB_TAG_LEN], mem_size[2]} from ACU.
- alloc_enable  in  1  ACU requests allocation of sb_packet_in.
- commit_store  in  1  ROB retires the oldest uncommitted store this cycle.
- mem_busy  in  1  MEM cannot accept a write this cycle.
- full  out  1  all SB_DEPTH entries occupied; to ACU.
- pending_stores  out  1  at least one entry occupied; to ROB and load_buffer.
- store_address  out  `XLEN  address of the most recently allocated store; to ROB.
- store_rob_tag  out  `ROB_TAG_LEN  rob_tag of the most recently allocated store; to ROB.
- write_mem  out  1  write request to MEM this cycle.
- mem_address  out  `XLEN  head entry address.
- mem_data  out  `XLEN  head entry data.
- mem_size  out  2  head entry size.

Behaviour:
- State:
  - Circular FIFO with head, tail and commit pointers, each $clog2(SB_DEPTH) bits and wrapping modulo SB_DEPTH.
  - count = occupied entries; ccount = committed entries.
  - Each entry is in state FREE, WAIT_COMMIT or COMMITTED.
- Reset (reset=0, asynchronous):
  - Pointers, count and ccount go to 0; all entries FREE.
  - store_address = 0, store_rob_tag = 0.
  - write_mem, full and pending_stores = 0.
  - mem_address, mem_data and mem_size = 0.
  - Reset mid-operation discards all entries, including committed ones.
- Allocation:
  - Accepted at posedge when alloc_enable && sb_packet_in.valid && !full.
  - The entry is written at tail in state WAIT_COMMIT, and tail and count advance.
  - store_address and store_rob_tag register the packet fields on the same edge and hold until the next accepted allocation.
  - alloc_enable with valid=0, or with full=1, leaves all state unchanged.
- Commit:
  - At posedge, commit_store moves the entry at the commit pointer from WAIT_COMMIT to COMMITTED, and the commit pointer and ccount advance.
  - Commit only sees entries present before the edge, so a store allocated in the same cycle cannot be committed by it.
  - commit_store with no WAIT_COMMIT entry is ignored.
- Drain (combinational request):
  - write_mem = (ccount != 0) && !mem_busy.
  - mem_address, mem_data and mem_size always show the head entry, or 0 when empty.
  - At posedge with write_mem=1, the head is freed, and head, count and ccount decrement/advance.
  - mem_busy=1 holds the head indefinitely; no data is lost.
- Flags, all derived from registered count only:
  - full = (count == SB_DEPTH).
  - pending_stores = (count != 0).
- Simultaneous events:
  - Allocation, commit and drain in one cycle all apply.
  - Allocation while full is rejected even if a drain frees an entry that cycle; full deasserts the following cycle.
  - Commit and drain in the same cycle: ccount stays unchanged.
- Ordering: stores reach MEM strictly in allocation order; no coalescing and no forwarding.

Optional Feature:
- Macro: SB_SQUASH_EN.
- With the macro defined:
  - Adds input squash (1 bit, from ROB on mispredict/exception).
  - At posedge with squash=1, all WAIT_COMMIT entries become FREE: tail = commit pointer, count = ccount (after any same-cycle commit and drain).
  - Allocation that cycle is discarded.
  - Committed entries continue draining normally.
  - store_address and store_rob_tag keep their last values.
- Without the macro: no squash port; entries leave only via drain or reset.

Test Plan:
- Reset then idle: full=0, pending_stores=0, write_mem=0, store_address=0, store_rob_tag=0, mem_address=0.
- Allocation visibility:
  - Stimulus: alloc {1, 0x10, 0xAA, tag 2, size 2} with mem_busy=0, no commit.
  - Response: next cycle store_address=0x10, store_rob_tag=2, pending_stores=1, write_mem=0.
  - Then commit_store for 1 cycle: the cycle after, write_mem=1, mem_address=0x10, mem_data=0xAA, mem_size=2.
  - The cycle after that: pending_stores=0.
- Fill 4 stores with tags 1..4:
  - full=1 after the 4th.
  - A 5th alloc is rejected: store_rob_tag stays 4.
  - Commit all 4 with mem_busy=1: write_mem=0 throughout.
  - Release mem_busy: 4 consecutive writes with addresses in allocation order, then full=0 after the first drain and pending_stores=0 after the fourth.
- Wrap-around: run 6 alloc/commit/drain cycles through SB_DEPTH=4; MEM sees addresses 0x0..0x14 in order; pointers wrap with no corruption.
- Same-cycle allocation and commit into an empty buffer: commit is ignored; entry stays uncommitted (write_mem=0) until a later commit_store.
- SB_SQUASH_EN:
  - Stimulus: 3 entries, 1 committed, mem_busy=1, then assert squash with a simultaneous alloc.
  - Response: count=1 and full=0; after mem_busy=0 exactly one write occurs, then pending_stores=0.
